// File: rtl/seven_seg_scanner_if.sv
// ============================================================================
// Module   : seven_seg_scanner_if
// Brief    : Display-word and segment/anode bundle of the 7-segment scanner.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      enable;
    logic [4*NUM_DIGITS-1:0]   value;
    logic                      load;
    logic                      lz_en;
    logic [3:0]                nib_out;
    logic [6:0]                seg_in;
    logic [6:0]                seg_out;
    logic [NUM_DIGITS-1:0]     an_out;
    logic                      pending;
    logic                      frame_done;

    modport master (
        output enable, value, load, lz_en, seg_in,
        input  nib_out, seg_out, an_out, pending, frame_done
    );

    modport slave (
        input  enable, value, load, lz_en, seg_in,
        output nib_out, seg_out, an_out, pending, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/seven_seg_scanner.sv
// ============================================================================
// Module   : seven_seg_scanner
// Brief    : Multiplexed common-anode display scanner, double-buffered word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  wire                   clk,
    input  wire                   reset,
    seven_seg_scanner_if.slave    bus
);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] c_BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] c_SLOT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] c_DIG_LAST   = DW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CW-1:0]           r_div_cnt;
    logic [CW-1:0]           w_div_nxt;
    logic [DW-1:0]           r_dig_idx;
    logic [DW-1:0]           w_idx_nxt;
    logic [4*NUM_DIGITS-1:0] r_display_q;
    logic [4*NUM_DIGITS-1:0] r_pend_q;
    logic                    r_pending;
    logic [6:0]              r_seg_out;
    logic [NUM_DIGITS-1:0]   r_an_out;
    logic                    r_frame_done;
    logic                    w_slot_end;
    logic                    w_boundary;
    logic                    w_lit;
    logic                    w_acc;
    logic [NUM_DIGITS-1:0]   w_zero_hi;

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div_cnt;
        w_idx_nxt   = r_dig_idx;
        w_slot_end  = 1'b0;
        if (!bus.enable) begin
            w_state_nxt = S_IDLE;
            w_div_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_BLANK;
                    w_div_nxt   = '0;
                    w_idx_nxt   = '0;
                end
                S_BLANK: begin
                    w_div_nxt = r_div_cnt + 1'b1;
                    if (r_div_cnt == c_BLANK_LAST) begin
                        w_state_nxt = S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (r_div_cnt == c_SLOT_LAST) begin
                        w_slot_end  = 1'b1;
                        w_state_nxt = S_BLANK;
                        w_div_nxt   = '0;
                        w_idx_nxt   = (r_dig_idx == c_DIG_LAST) ? '0 : r_dig_idx + 1'b1;
                    end else begin
                        w_div_nxt = r_div_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_div_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // w_zero_hi[i] is set when every nibble from the top down to digit i is zero.
    always_comb begin
        w_acc     = 1'b1;
        w_zero_hi = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_acc        = w_acc & (r_display_q[4*i +: 4] == 4'd0);
            w_zero_hi[i] = w_acc;
        end
    end

    assign w_boundary = (w_slot_end && (r_dig_idx == c_DIG_LAST))
                     || ((r_state == S_IDLE) && bus.enable);
    assign w_lit      = bus.enable && (r_state == S_DRIVE)
                     && !(bus.lz_en && (r_dig_idx != '0) && w_zero_hi[r_dig_idx]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_div_cnt    <= '0;
            r_dig_idx    <= '0;
            r_display_q  <= '0;
            r_pend_q     <= '0;
            r_pending    <= 1'b0;
            r_seg_out    <= 7'h7F;
            r_an_out     <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_div_cnt    <= w_div_nxt;
            r_dig_idx    <= w_idx_nxt;
            r_frame_done <= w_slot_end && (r_dig_idx == c_DIG_LAST);
            if (w_lit) begin
                r_seg_out <= bus.seg_in;
                r_an_out  <= ~(NUM_DIGITS'(1) << r_dig_idx);
            end else begin
                r_seg_out <= 7'h7F;
                r_an_out  <= '1;
            end

            if (bus.load) begin
                r_pend_q <= bus.value;
            end
            // A load on the boundary edge bypasses the pending buffer entirely.
            if (w_boundary) begin
                if (bus.load) begin
                    r_display_q <= bus.value;
                end else if (r_pending) begin
                    r_display_q <= r_pend_q;
                end
                r_pending <= 1'b0;
            end else if (r_state == S_IDLE) begin
                if (bus.load) begin
                    r_display_q <= bus.value;
                    r_pending   <= 1'b0;
                end
            end else if (bus.load) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign bus.nib_out    = r_display_q[4*r_dig_idx +: 4];
    assign bus.seg_out    = r_seg_out;
    assign bus.an_out     = r_an_out;
    assign bus.pending    = r_pending;
    assign bus.frame_done = r_frame_done;

endmodule

`default_nettype wire
